// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: request/status handshake between a command source and
// the PS/2 host transmitter.
//   iData     [7:0]  command byte, taken when iValid && oReady
//   iValid           request to send iData
//   oReady           transmitter idle and able to accept a byte
//   oDone            1-cycle pulse: byte sent and device ACK seen
//   oAckErr          1-cycle pulse: device ACK bit was high
//   oTimeout         1-cycle pulse: device stopped clocking / bus never idled
//   oTxActive        transmitter owns the bus; the receiver ignores it
// Modports: master = command source, slave = transmitter.
interface ps2_host_tx_if;
  logic [7:0] iData;
  logic       iValid;
  logic       oReady;
  logic       oDone;
  logic       oAckErr;
  logic       oTimeout;
  logic       oTxActive;

  modport master (
    output iData, iValid,
    input  oReady, oDone, oAckErr, oTimeout, oTxActive
  );

  modport slave (
    input  iData, iValid,
    output oReady, oDone, oAckErr, oTimeout, oTxActive
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte
// (start, d0..d7 LSB first, odd parity, stop) to the mouse and checks the
// device ACK. Shares the pins with the receiver through open-drain enables.
// Ports:
//   sysClk, iRst_n        system clock, asynchronous active-low reset
//   bus (slave modport)   iData/iValid request, oReady/oDone/oAckErr/
//                         oTimeout/oTxActive status
//   ps2clk_i, ps2data_i   raw pin levels
//   ps2clk_oe, ps2data_oe 1 = pull the pin low, 0 = release
// Optional feature: define PS2_TX_RETRY_EN to retry a failed frame up to
// two more times before reporting the error.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int FILTER_LEN  = 8
) (
  input  logic         sysClk,
  input  logic         iRst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2clk_i,
  input  logic         ps2data_i,
  output logic         ps2clk_oe,
  output logic         ps2data_oe
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [31:0]   INH_LAST  = 32'(INHIBIT_CYC - 1);
  localparam logic [31:0]   TMO_LAST  = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAITIDLE
  } state_t;

  // Two-flop synchronisers; bit 0 = ps2clk, bit 1 = ps2data. Idle bus is high.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  assign pin_raw = {ps2data_i, ps2clk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic s1_reg, s2_reg;
    always_ff @(posedge sysClk or negedge iRst_n) begin
      if (!iRst_n) begin
        s1_reg <= 1'b1;
        s2_reg <= 1'b1;
      end else begin
        s1_reg <= pin_raw[gi];
        s2_reg <= s1_reg;
      end
    end
    assign pin_sync[gi] = s2_reg;
  end

  logic clk_sync, data_sync;
  assign clk_sync  = pin_sync[0];
  assign data_sync = pin_sync[1];

  // ps2clk level filter: a new level is accepted on its FILTER_LEN-th
  // consecutive sample, so shorter glitches never produce a fall.
  logic [FW-1:0] filt_cnt_reg;
  logic          clk_filt_reg;
  logic          filt_flip, fall;
  assign filt_flip = (clk_sync != clk_filt_reg) && (filt_cnt_reg == FILT_LAST);
  assign fall      = filt_flip && clk_filt_reg;

  always_ff @(posedge sysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      filt_cnt_reg <= '0;
      clk_filt_reg <= 1'b1;
    end else if (clk_sync == clk_filt_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_flip) begin
      clk_filt_reg <= clk_sync;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  logic can_retry;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt_reg;
  assign can_retry = (retry_cnt_reg != 2'd2);
`else
  assign can_retry = 1'b0;
`endif

  state_t      state_reg;
  logic [7:0]  data_reg;
  logic        parity_reg;
  logic [9:0]  frame_reg;    // remaining bits to present: d0..d7, parity, stop
  logic [3:0]  bit_idx_reg;
  logic [31:0] cnt_reg;      // inhibit length, then cycles since last fall
  logic        err_reg;
  logic        ready_reg, done_reg, ackerr_reg, timeout_reg, active_reg;
  logic        clk_oe_reg, data_oe_reg;

  always_ff @(posedge sysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_reg   <= S_IDLE;
      data_reg    <= '0;
      parity_reg  <= 1'b0;
      frame_reg   <= '0;
      bit_idx_reg <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
      ackerr_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      active_reg  <= 1'b0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_reg <= '0;
`endif
    end else begin
      done_reg    <= 1'b0;
      ackerr_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.iValid) begin
            data_reg    <= bus.iData;
            parity_reg  <= ~^bus.iData;
            cnt_reg     <= '0;
            clk_oe_reg  <= 1'b1;
            ready_reg   <= 1'b0;
            active_reg  <= 1'b1;
            state_reg   <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_cnt_reg <= '0;
`endif
          end
        end
        S_INHIBIT: begin
          if (cnt_reg == INH_LAST) begin
            data_oe_reg <= 1'b1;  // start bit, held through SEND until fall 1
            frame_reg   <= {1'b1, parity_reg, data_reg};
            bit_idx_reg <= '0;
            state_reg   <= S_REQ;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        S_REQ: begin
          clk_oe_reg <= 1'b0;
          cnt_reg    <= '0;
          err_reg    <= 1'b0;
          state_reg  <= S_SEND;
        end
        S_SEND, S_ACK, S_WAITIDLE: begin
          // Fires on the TIMEOUT_CYC-th consecutive cycle without a fall;
          // checked before the fall so it wins a coincident edge.
          if (cnt_reg == TMO_LAST) begin
            data_oe_reg <= 1'b0;
            cnt_reg     <= '0;
            if (can_retry) begin
              clk_oe_reg <= 1'b1;
              state_reg  <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_cnt_reg <= retry_cnt_reg + 2'd1;
`endif
            end else begin
              clk_oe_reg  <= 1'b0;
              timeout_reg <= 1'b1;
              ready_reg   <= 1'b1;
              active_reg  <= 1'b0;
              state_reg   <= S_IDLE;
            end
          end else begin
            cnt_reg <= fall ? 32'd0 : cnt_reg + 32'd1;
            case (state_reg)
              S_SEND: begin
                if (fall) begin
                  data_oe_reg <= ~frame_reg[0];
                  frame_reg   <= frame_reg >> 1;
                  bit_idx_reg <= bit_idx_reg + 4'd1;
                  if (bit_idx_reg == 4'd9) state_reg <= S_ACK;
                end
              end
              S_ACK: begin
                if (fall) begin
                  state_reg <= S_WAITIDLE;
                  if (data_sync) begin
                    err_reg <= 1'b1;
                    if (!can_retry) ackerr_reg <= 1'b1;
                  end
                end
              end
              S_WAITIDLE: begin
                if (clk_filt_reg && data_sync) begin
                  if (err_reg && can_retry) begin
                    cnt_reg    <= '0;
                    clk_oe_reg <= 1'b1;
                    state_reg  <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_cnt_reg <= retry_cnt_reg + 2'd1;
`endif
                  end else begin
                    done_reg   <= ~err_reg;
                    ready_reg  <= 1'b1;
                    active_reg <= 1'b0;
                    state_reg  <= S_IDLE;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ps2clk_oe     = clk_oe_reg;
  assign ps2data_oe    = data_oe_reg;
  assign bus.oReady    = ready_reg;
  assign bus.oDone     = done_reg;
  assign bus.oAckErr   = ackerr_reg;
  assign bus.oTimeout  = timeout_reg;
  assign bus.oTxActive = active_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2
// device on the open-drain pins. Parameters are scaled down so a whole
// frame takes about a thousand cycles.
module tb_ps2_host_tx;
  localparam int INH = 120;
  localparam int TMO = 3000;
  localparam int FLT = 8;
  localparam int H   = 40;   // device clock half period in sysClk cycles

  logic sysClk = 1'b0;
  logic iRst_n = 1'b1;
  always #5 sysClk = ~sysClk;

  ps2_host_tx_if bus();
  logic ps2clk_oe, ps2data_oe;
  logic ps2clk_i, ps2data_i;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  // Wired-AND bus with pull-ups.
  assign ps2clk_i  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_i = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER_LEN(FLT)) dut (
    .sysClk    (sysClk),
    .iRst_n    (iRst_n),
    .bus       (bus),
    .ps2clk_i  (ps2clk_i),
    .ps2data_i (ps2data_i),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, ackerr_cnt = 0, tmo_cnt = 0;

  always @(negedge sysClk) begin
    if (bus.oDone === 1'b1)    done_cnt   <= done_cnt + 1;
    if (bus.oAckErr === 1'b1)  ackerr_cnt <= ackerr_cnt + 1;
    if (bus.oTimeout === 1'b1) tmo_cnt    <= tmo_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] b);
    @(negedge sysClk);
    bus.iData  = b;
    bus.iValid = 1'b1;
    @(negedge sysClk);
    bus.iValid = 1'b0;
  endtask

  // Device: wait for the request-to-send, then clock nfalls cycles, sampling
  // data late in each low phase. bits[0] = start, bits[10] = stop.
  task automatic dev_frame(input int nfalls, input bit ack_ok, input int glitch_after,
                           output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(ps2clk_i === 1'b1 && ps2data_i === 1'b0) && w < 3 * INH) begin
      @(negedge sysClk);
      w++;
    end
    chk("req_seen", 32'(w < 3 * INH), 32'd1);
    repeat (H) @(negedge sysClk);
    bits[0] = ps2data_i;
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && ack_ok) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (H) @(negedge sysClk);
      if (k <= 10) bits[k] = ps2data_i;
      dev_clk_low = 1'b0;
      if (k == glitch_after) begin
        repeat (10) @(negedge sysClk);
        dev_clk_low = 1'b1;
        bus.iData   = 8'h00;
        bus.iValid  = 1'b1;
        repeat (3) @(negedge sysClk);
        dev_clk_low = 1'b0;
        bus.iValid  = 1'b0;
        repeat (H - 13) @(negedge sysClk);
      end else begin
        repeat (H) @(negedge sysClk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (bus.oDone !== 1'b1 && w < 200) begin
      @(negedge sysClk);
      w++;
    end
    chk({tag, "_done_seen"}, 32'(bus.oDone), 32'd1);
    chk({tag, "_ready_with_done"}, 32'(bus.oReady), 32'd1);
    @(negedge sysClk);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    int d0, a0, t0, n;
    bus.iData  = 8'h00;
    bus.iValid = 1'b0;
    #2 iRst_n = 1'b0;
    repeat (3) @(negedge sysClk);
    iRst_n = 1'b1;
    @(negedge sysClk);

    // Reset state
    chk("rst_ready",    32'(bus.oReady),    32'd1);
    chk("rst_done",     32'(bus.oDone),     32'd0);
    chk("rst_ackerr",   32'(bus.oAckErr),   32'd0);
    chk("rst_timeout",  32'(bus.oTimeout),  32'd0);
    chk("rst_active",   32'(bus.oTxActive), 32'd0);
    chk("rst_clk_oe",   32'(ps2clk_oe),     32'd0);
    chk("rst_data_oe",  32'(ps2data_oe),    32'd0);

    // 1: 0xF4 -> start 0, 0,0,1,0,1,1,1,1, parity 0, stop 1
    d0 = done_cnt;
    send_req(8'hF4);
    chk("t1_active", 32'(bus.oTxActive), 32'd1);
    chk("t1_ready_busy", 32'(bus.oReady), 32'd0);
    dev_frame(11, 1'b1, 0, bits);
    chk("t1_bits", 32'(bits), 32'(11'b10_1111_0100_0));
    wait_done("t1");
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // 2: 0xFF -> parity 1; clock inhibit lasts exactly INH cycles
    d0 = done_cnt;
    @(negedge sysClk);
    bus.iData  = 8'hFF;
    bus.iValid = 1'b1;
    @(negedge sysClk);
    bus.iValid = 1'b0;
    n = 0;
    while (ps2data_oe !== 1'b1 && n < 1000) begin
      if (ps2clk_oe === 1'b1) n++;
      @(negedge sysClk);
    end
    chk("t2_inhibit_cycles", 32'(n), 32'(INH));
    dev_frame(11, 1'b1, 0, bits);
    chk("t2_bits", 32'(bits), 32'(11'b11_1111_1111_0));
    wait_done("t2");
    chk("t2_done_count", 32'(done_cnt - d0), 32'd1);

    // 3: device leaves ACK high
    d0 = done_cnt; a0 = ackerr_cnt;
    send_req(8'hF4);
    dev_frame(11, 1'b0, 0, bits);
    chk("t3_bits", 32'(bits), 32'(11'b10_1111_0100_0));
    repeat (100) @(negedge sysClk);
    chk("t3_ackerr_count", 32'(ackerr_cnt - a0), 32'd1);
    chk("t3_done_count",   32'(done_cnt - d0),   32'd0);
    chk("t3_ready",        32'(bus.oReady),      32'd1);

    // 4: device never clocks -> timeout TMO cycles after entering SEND
    t0 = tmo_cnt; d0 = done_cnt;
    send_req(8'hF4);
    n = 0;
    while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && n < 3 * INH) begin
      @(negedge sysClk);
      n++;
    end
    chk("t4_send_entered", 32'(n < 3 * INH), 32'd1);
    n = 0;
    while (bus.oTimeout !== 1'b1 && n < TMO + 100) begin
      @(negedge sysClk);
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'(TMO));
    chk("t4_clk_oe",  32'(ps2clk_oe),  32'd0);
    chk("t4_data_oe", 32'(ps2data_oe), 32'd0);
    chk("t4_ready",   32'(bus.oReady), 32'd1);
    repeat (5) @(negedge sysClk);
    chk("t4_timeout_count", 32'(tmo_cnt - t0), 32'd1);
    chk("t4_done_count",    32'(done_cnt - d0), 32'd0);

    // 5: reset after fall 5 of 0x0F (d4 = 0, so data is being driven low)
    d0 = done_cnt; a0 = ackerr_cnt; t0 = tmo_cnt;
    send_req(8'h0F);
    dev_frame(5, 1'b0, 0, bits);
    chk("t5_partial_bits", 32'(bits[5:0]), 32'(6'b011110));
    chk("t5_data_oe_before", 32'(ps2data_oe), 32'd1);
    #2 iRst_n = 1'b0;
    #1;
    chk("t5_clk_oe_rst",  32'(ps2clk_oe),      32'd0);
    chk("t5_data_oe_rst", 32'(ps2data_oe),     32'd0);
    chk("t5_ready_rst",   32'(bus.oReady),     32'd1);
    chk("t5_active_rst",  32'(bus.oTxActive),  32'd0);
    @(negedge sysClk);
    iRst_n = 1'b1;
    repeat (20) @(negedge sysClk);
    chk("t5_no_status", 32'((done_cnt - d0) + (ackerr_cnt - a0) + (tmo_cnt - t0)), 32'd0);
    send_req(8'hF4);
    dev_frame(11, 1'b1, 0, bits);
    chk("t5_bits", 32'(bits), 32'(11'b10_1111_0100_0));
    wait_done("t5");

    // 6: 3-cycle clock glitch and iValid pulse during SEND
    d0 = done_cnt;
    send_req(8'hF4);
    dev_frame(11, 1'b1, 3, bits);
    chk("t6_bits", 32'(bits), 32'(11'b10_1111_0100_0));
    wait_done("t6");
    repeat (400) @(negedge sysClk);
    chk("t6_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t6_no_second_frame", 32'(bus.oTxActive), 32'd0);
    chk("t6_clk_released", 32'(ps2clk_oe), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
